// File: rtl/elevador_multiandar.sv
`default_nettype none
// ============================================================================
//  Module   : elevador_multiandar
//  Purpose  : Multi-floor elevator controller. Boards at floor 0, climbs and
//             unloads at each requested floor, returns empty to floor 0.
//             Optional door-hold button enabled by macro ELEV_DOOR_HOLD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module elevador_multiandar #(
    parameter  int NFLOORS    = 4,
    parameter  int CAP        = 2,
    parameter  int WAIT_CYC   = 2,
    parameter  int TRAVEL_CYC = 2,
    localparam int FW         = $clog2(NFLOORS),
    localparam int CW         = $clog2(CAP + 1)
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          pessoa,
    input  logic [FW-1:0] destino,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic          hold,
`endif
    output logic [FW-1:0] andar,
    output logic          porta,
    output logic [CW-1:0] ocupacao,
    output logic [1:0]    estado,
    output logic          err
);

    localparam int WW = $clog2(WAIT_CYC + 1);
    localparam int TW = $clog2(TRAVEL_CYC + 1);

    localparam logic [WW-1:0] c_WAIT  = WW'(WAIT_CYC);
    localparam logic [TW-1:0] c_TLAST = TW'(TRAVEL_CYC - 1);
    localparam logic [CW-1:0] c_CAP   = CW'(CAP);
    localparam logic [FW-1:0] c_TOP   = FW'(NFLOORS - 1);
    localparam logic [FW:0]   c_NFL   = (FW+1)'(NFLOORS);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_UP     = 2'd1,
        S_UNLOAD = 2'd2,
        S_DOWN   = 2'd3
    } state_t;

    state_t          r_state;
    logic [FW-1:0]   r_andar;
    logic            r_porta;
    logic [CW-1:0]   r_occ;
    logic            r_err;
    logic [WW-1:0]   r_wait;
    logic [TW-1:0]   r_tcnt;
    logic [CW-1:0]   r_dwell;
    logic [CW-1:0]   r_req [NFLOORS];

    logic            w_hold;
    logic            w_dest_ok;
    logic            w_board_ok;
    logic            w_depart;
    logic            w_travel_done;
    logic [FW-1:0]   w_next_up;
    logic [FW-1:0]   w_next_dn;

`ifdef ELEV_DOOR_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_dest_ok     = (destino != '0) && ({1'b0, destino} < c_NFL);
    assign w_board_ok    = pessoa && w_dest_ok && (r_occ < c_CAP);
    assign w_depart      = !w_hold && ((r_occ == c_CAP) || (r_wait == c_WAIT));
    assign w_travel_done = (r_tcnt == c_TLAST);
    assign w_next_up     = r_andar + 1'b1;
    assign w_next_dn     = r_andar - 1'b1;

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD;
            r_andar <= '0;
            r_porta <= 1'b1;
            r_occ   <= '0;
            r_err   <= 1'b0;
            r_wait  <= '0;
            r_tcnt  <= '0;
            r_dwell <= '0;
            for (int i = 0; i < NFLOORS; i++) begin
                r_req[i] <= '0;
            end
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    // A boarding on the departure edge still rides along.
                    if (pessoa) begin
                        if (w_board_ok) begin
                            r_occ          <= r_occ + 1'b1;
                            r_req[destino] <= r_req[destino] + 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    if (w_depart) begin
                        r_state <= S_UP;
                        r_porta <= 1'b0;
                        r_wait  <= '0;
                        r_tcnt  <= '0;
                    end else if ((r_occ != '0) && !w_hold) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                S_UP: begin
                    if (w_travel_done) begin
                        r_tcnt <= '0;
                        if (r_andar != c_TOP) begin
                            r_andar <= w_next_up;
                            if (r_req[w_next_up] != '0) begin
                                r_state <= S_UNLOAD;
                                r_porta <= 1'b1;
                                r_dwell <= r_req[w_next_up];
                            end
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                S_UNLOAD: begin
                    if (!w_hold) begin
                        if (r_dwell <= CW'(1)) begin
                            r_occ          <= r_occ - r_req[r_andar];
                            r_req[r_andar] <= '0;
                            r_porta        <= 1'b0;
                            r_dwell        <= '0;
                            r_tcnt         <= '0;
                            r_state        <= (r_occ == r_req[r_andar]) ? S_DOWN : S_UP;
                        end else begin
                            r_dwell <= r_dwell - 1'b1;
                        end
                    end
                end

                S_DOWN: begin
                    if (w_travel_done || (r_andar == '0)) begin
                        r_tcnt <= '0;
                        if (r_andar != '0) begin
                            r_andar <= w_next_dn;
                        end
                        if ((r_andar == '0) || (w_next_dn == '0)) begin
                            r_state <= S_LOAD;
                            r_porta <= 1'b1;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_LOAD;
                    r_porta <= 1'b1;
                end
            endcase
        end
    end

    assign andar    = r_andar;
    assign porta    = r_porta;
    assign ocupacao = r_occ;
    assign estado   = r_state;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_elevador_multiandar.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevador_multiandar
//  Purpose  : Self-checking bench: trip-level reference model plus directed
//             literal checks and randomized boarding traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_elevador_multiandar;

    localparam int NFLOORS    = 4;
    localparam int CAP        = 2;
    localparam int WAIT_CYC   = 2;
    localparam int TRAVEL_CYC = 2;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       pessoa;
    logic [1:0] destino;
    logic       hold;
    logic [1:0] andar;
    logic       porta;
    logic [1:0] ocupacao;
    logic [1:0] estado;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    elevador_multiandar #(
        .NFLOORS(NFLOORS), .CAP(CAP), .WAIT_CYC(WAIT_CYC), .TRAVEL_CYC(TRAVEL_CYC)
    ) dut (
        .clk_2(clk_2),
        .reset(reset),
        .pessoa(pessoa),
        .destino(destino),
`ifdef ELEV_DOOR_HOLD_EN
        .hold(hold),
`endif
        .andar(andar),
        .porta(porta),
        .ocupacao(ocupacao),
        .estado(estado),
        .err(err)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model: whole trips planned as output snapshots
    typedef struct packed {
        logic [1:0] est;
        logic [1:0] an;
        logic       po;
        logic [1:0] oc;
    } snap_t;

    snap_t      sched[$];
    int         m_dest[$];
    int         m_wait;
    bit         m_trip;
    logic [1:0] e_est, e_an, e_oc;
    logic       e_po, e_err;
    logic       m_hold;
    int         sz0;
    bit         acc, leave;
    snap_t      s;

`ifdef ELEV_DOOR_HOLD_EN
    assign m_hold = hold;
`else
    assign m_hold = 1'b0;
`endif

    function automatic snap_t mk(int est, int an, int po, int oc);
        snap_t t;
        t.est = 2'(est); t.an = 2'(an); t.po = 1'(po); t.oc = 2'(oc);
        return t;
    endfunction

    task automatic plan_trip();
        int n[NFLOORS];
        int top = 0;
        int occ = m_dest.size();
        foreach (n[i]) n[i] = 0;
        foreach (m_dest[i]) begin
            n[m_dest[i]]++;
            if (m_dest[i] > top) top = m_dest[i];
        end
        for (int f = 1; f <= top; f++) begin
            repeat (TRAVEL_CYC) sched.push_back(mk(1, f - 1, 0, occ));
            repeat (n[f]) sched.push_back(mk(2, f, 1, occ));
            occ -= n[f];
        end
        for (int g = top; g >= 1; g--) begin
            repeat (TRAVEL_CYC) sched.push_back(mk(3, g, 0, 0));
        end
        sched.push_back(mk(0, 0, 1, 0));
    endtask

    always @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            sched.delete(); m_dest.delete();
            m_wait = 0; m_trip = 0;
            e_est = 0; e_an = 0; e_po = 1; e_oc = 0; e_err = 0;
        end else begin
            e_err = 0;
            if (!m_trip) begin
                sz0   = m_dest.size();
                leave = !m_hold && (sz0 == CAP || m_wait == WAIT_CYC);
                acc   = pessoa && destino >= 1 && int'(destino) < NFLOORS && sz0 < CAP;
                if (pessoa && !acc) e_err = 1;
                if (acc) m_dest.push_back(int'(destino));
                if (leave) begin
                    m_wait = 0;
                    plan_trip();
                    m_trip = 1;
                    s = sched.pop_front();
                    {e_est, e_an, e_po, e_oc} = s;
                end else begin
                    if (sz0 >= 1 && !m_hold) m_wait++;
                    e_est = 0; e_an = 0; e_po = 1; e_oc = 2'(m_dest.size());
                end
            end else if (sched.size() > 0) begin
                s = sched.pop_front();
                {e_est, e_an, e_po, e_oc} = s;
                if (s.est == 2'd0) begin
                    m_trip = 0; m_dest.delete(); m_wait = 0;
                end
            end
        end
    end

    always @(negedge clk_2) begin
        if (reset === 1'b1) begin
            check("outputs{andar,porta,ocup,estado,err}",
                  int'({andar, porta, ocupacao, estado, err}),
                  int'({e_an, e_po, e_oc, e_est, e_err}));
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk_2);
        #2;
    endtask

    task automatic apply_reset();
        pessoa = 0; destino = 0; hold = 0;
        reset = 0;
        tick(); tick();
        reset = 1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [29:0] an_tr;
        logic [14:0] po_tr;
        int          n, cnt;

        reset = 0; pessoa = 0; destino = 0; hold = 0;
        tick(); tick();
        check("reset_state", int'({andar, porta, ocupacao, estado, err}), 8'h20);
        reset = 1;

        // Full car to floor 3: exact floor/door trace of the whole trip.
        pessoa = 1; destino = 3;
        tick(); tick();
        pessoa = 0;
        an_tr = '0; po_tr = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            an_tr = {an_tr[27:0], andar};
            po_tr = {po_tr[13:0], porta};
        end
        check("trip3_andar_trace", int'(an_tr), 30'b00_00_01_01_10_10_11_11_11_11_10_10_01_01_00);
        check("trip3_porta_trace", int'(po_tr), 15'b000000110000001);

        // Async reset while climbing.
        apply_reset();
        pessoa = 1; destino = 2;
        tick(); tick();
        pessoa = 0;
        tick(); tick();
        check("midup_estado_before_reset", int'(estado), 1);
        reset = 0;
        #1;
        check("midup_async_reset", int'({andar, porta, ocupacao, estado, err}), 8'h20);
        tick();
        reset = 1;

        // Single passenger: departs on wait timeout, one door cycle at floor 1.
        apply_reset();
        pessoa = 1; destino = 1;
        tick();
        pessoa = 0;
        n = 0;
        while (estado != 2'd1 && n < 20) begin tick(); n++; end
        check("single_wait_edges", n, 3);
        cnt = 0; n = 0;
        while (n < 30) begin
            tick(); n++;
            if (estado == 2'd0) break;
            cnt += int'(porta);
        end
        check("single_door_cycles", cnt, 1);

        // Two passengers to floors 1 and 3.
        apply_reset();
        pessoa = 1; destino = 1; tick();
        destino = 3; tick();
        pessoa = 0;
        n = 0;
        while (estado != 2'd2 && n < 30) begin tick(); n++; end
        check("two_stop1_floor", int'(andar), 1);
        check("two_stop1_ocup", int'(ocupacao), 2);
        tick();
        check("two_after_stop1", int'({ocupacao, estado, porta}), {2'd1, 2'd1, 1'b0});
        n = 0;
        while (estado != 2'd2 && n < 30) begin tick(); n++; end
        check("two_stop3_floor", int'(andar), 3);
        tick();
        check("two_after_stop3", int'({ocupacao, estado}), {2'd0, 2'd3});

        // Rejections: floor-0 destination, then boarding while full.
        apply_reset();
        pessoa = 1; destino = 0; tick();
        check("err_dest0", int'({err, ocupacao}), {1'b1, 2'd0});
        pessoa = 0; tick();
        check("err_clears", int'(err), 0);
        pessoa = 1; destino = 2; tick(); tick(); tick();
        check("err_full", int'({err, ocupacao}), {1'b1, 2'd2});
        pessoa = 0;

`ifdef ELEV_DOOR_HOLD_EN
        // Door hold keeps a full car at floor 0.
        apply_reset();
        hold = 1; pessoa = 1; destino = 3;
        tick(); tick();
        pessoa = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_no_depart", int'(estado), 0);
        end
        hold = 0;
        tick();
        check("hold_release_up", int'(estado), 1);
`endif

        // Randomized traffic against the model.
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            pessoa  = ($urandom % 3) == 0;
            destino = 2'($urandom % 4);
`ifdef ELEV_DOOR_HOLD_EN
            hold = !m_trip && (($urandom % 4) == 0);
`endif
            if (($urandom % 800) == 0) begin
                reset = 0;
                tick();
                reset = 1;
            end else begin
                tick();
            end
        end

        pessoa = 0; hold = 0;
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
